// File: rtl/dcache_responder_if.sv
// CPU data-port bundle between the datapath and the data memory responder.
interface dcache_responder_if;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  modport master (
    output dcache_addr, dcache_re, dcache_we, dcache_din,
    input  dcache_dout, stall, err, rd_count, wr_count
  );

  modport slave (
    input  dcache_addr, dcache_re, dcache_we, dcache_din,
    output dcache_dout, stall, err, rd_count, wr_count
  );
endinterface

// File: rtl/dcache_responder.sv
// Fixed-latency data memory responder: byte-masked stores, loads, stall generation,
// sticky out-of-range error and completed-access counters.
module dcache_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  dcache_responder_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = DEPTH_LOG2;
  localparam int unsigned HI_LSB = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_re;
  logic             cap_wr;
  logic             cap_oor;
  logic [31:0]      mem [DEPTH];

  logic             req_c;
  logic             capture_c;
  logic             req_oor_c;
  logic             ld_c;
  logic             enter_resp_c;
  logic [IDX_W-1:0] req_idx_c;
  logic [31:0]      load_word_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

  assign req_c        = bus.dcache_re | (|bus.dcache_we);
  assign capture_c    = reset && (state == IDLE) && req_c;
  assign req_idx_c    = bus.dcache_addr[HI_LSB-1:2];
  assign req_oor_c    = (bus.dcache_addr >> HI_LSB) != 32'h0;
  assign enter_resp_c = reset && (state != RESP) && (state_nxt == RESP);
  assign ld_c         = (state == IDLE) ? bus.dcache_re : cap_re;

  // Load result as seen at entry to RESP; with single-cycle latency the store merges in directly.
  always_comb begin
    load_word_c = 32'h0;
    if (state == IDLE) begin
      if (!req_oor_c) load_word_c = merge_bytes(mem[req_idx_c], bus.dcache_din, bus.dcache_we);
    end else if (state == BUSY) begin
      if (!cap_oor) load_word_c = mem[cap_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_c) state_nxt = (LATENCY > 1) ? BUSY : RESP;
      BUSY:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is gated by reset so an abort releases the datapath without waiting for a clock.
  always_comb begin
    bus.stall = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    bus.stall = req_c;
        BUSY:    bus.stall = 1'b1;
        default: bus.stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt             <= '0;
      cap_idx         <= '0;
      cap_re          <= 1'b0;
      cap_wr          <= 1'b0;
      cap_oor         <= 1'b0;
      bus.dcache_dout <= 32'h0;
      bus.err         <= 1'b0;
      bus.rd_count    <= 32'h0;
      bus.wr_count    <= 32'h0;
    end else begin
      if (capture_c) begin
        cnt     <= CNT_W'(LATENCY - 1);
        cap_idx <= req_idx_c;
        cap_re  <= bus.dcache_re;
        cap_wr  <= |bus.dcache_we;
        cap_oor <= req_oor_c;
        if (req_oor_c) bus.err <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp_c && ld_c) bus.dcache_dout <= load_word_c;
      if (state == RESP) begin
        if (cap_re) bus.rd_count <= bus.rd_count + 32'd1;
        if (cap_wr) bus.wr_count <= bus.wr_count + 32'd1;
      end
    end
  end

  // Storage is not reset; a store commits at its capture edge.
  always_ff @(posedge clk) begin
    if (capture_c && !req_oor_c && (|bus.dcache_we))
      mem[req_idx_c] <= merge_bytes(mem[req_idx_c], bus.dcache_din, bus.dcache_we);
  end
endmodule
